// File: rtl/register_file_responder_pkg.sv
// Shared register-file package: array depth, address type and the
// scrub-sequencer state encoding used by the responder and its sequencer.
package register_file_responder_pkg;
  localparam int REGISTER_DEPTH = 32;
  localparam int RF_READ_PORTS  = 2;

  typedef logic [$clog2(REGISTER_DEPTH)-1:0] register_address_t;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } register_file_state_t;
endpackage

// File: rtl/register_file_clear_sequencer.sv
// Post-reset zero-scrub sequencer for the register file.
// Walks clear_index 0..DEPTH-1 issuing one zero write per cycle, then
// enters RUN and raises ready. Flags any writeback strobe seen while
// still scrubbing.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   write_enable_i         writeback strobe (monitored only)
//   clear_we_o             scrub write strobe into the array
//   clear_address_o        scrub write address
//   ready_o                1 = scrub complete
//   write_during_clear_o   sticky: write strobe seen before ready
module register_file_clear_sequencer
  import register_file_responder_pkg::*;
#(
  parameter int DEPTH = REGISTER_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write_enable_i,
  output logic          clear_we_o,
  output logic [AW-1:0] clear_address_o,
  output logic          ready_o,
  output logic          write_during_clear_o
);
  register_file_state_t state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 wdc_q, wdc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      wdc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdc_q   <= wdc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdc_d      = wdc_q;
    clear_we_o = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        clear_we_o = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (write_enable_i) wdc_d = 1'b1;
        // Last scrub write lands this cycle; RUN follows with no gap.
        if (idx_q == AW'(DEPTH - 1)) state_d = RF_RUN;
      end
      RF_RUN: ;
      default: state_d = RF_CLEAR;
    endcase
  end

  assign clear_address_o      = idx_q;
  assign ready_o              = (state_q == RF_RUN);
  assign write_during_clear_o = wdc_q;
endmodule

// File: rtl/register_file_responder.sv
// Integer register file: two combinational read ports with optional
// write-to-read bypass, one writeback write port, x0 hardwired to zero.
// The array has no reset; a post-reset scrub zeroes it and ready stays
// low until that completes.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   read_{1,2}_enable_i/address_i  read requests from decode
//   read_{1,2}_data_o              read data (0 when disabled, x0, or not ready)
//   write_enable_i/address_i/data_i writeback write port
//   ready_o                        scrub done, port serviced
//   write_during_clear_o           sticky: write strobe seen while not ready
module register_file_responder
  import register_file_responder_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int REGISTER_DEPTH = register_file_responder_pkg::REGISTER_DEPTH,
  parameter bit BYPASS_EN      = 1'b1,
  localparam int AW            = $clog2(REGISTER_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read_1_enable_i,
  input  logic [AW-1:0]    read_1_address_i,
  output logic [WIDTH-1:0] read_1_data_o,
  input  logic             read_2_enable_i,
  input  logic [AW-1:0]    read_2_address_i,
  output logic [WIDTH-1:0] read_2_data_o,
  input  logic             write_enable_i,
  input  logic [AW-1:0]    write_address_i,
  input  logic [WIDTH-1:0] write_data_i,
  output logic             ready_o,
  output logic             write_during_clear_o
);
  logic [WIDTH-1:0] regs [REGISTER_DEPTH];

  logic          clear_we;
  logic [AW-1:0] clear_address;
  logic          wr_ok;

  register_file_clear_sequencer #(.DEPTH(REGISTER_DEPTH)) u_seq (
    .clk                  (clk),
    .rst_n                (rst_n),
    .write_enable_i       (write_enable_i),
    .clear_we_o           (clear_we),
    .clear_address_o      (clear_address),
    .ready_o              (ready_o),
    .write_during_clear_o (write_during_clear_o)
  );

  assign wr_ok = ready_o && write_enable_i && (write_address_i != '0);

  // Single array write port: scrub owns it until ready, then writeback.
  always_ff @(posedge clk) begin
    if (clear_we)   regs[clear_address]   <= '0;
    else if (wr_ok) regs[write_address_i] <= write_data_i;
  end

  logic [RF_READ_PORTS-1:0]            rd_en;
  logic [RF_READ_PORTS-1:0][AW-1:0]    rd_addr;
  logic [RF_READ_PORTS-1:0][WIDTH-1:0] rd_data;

  assign rd_en   = {read_2_enable_i,  read_1_enable_i};
  assign rd_addr = {read_2_address_i, read_1_address_i};
  assign read_1_data_o = rd_data[0];
  assign read_2_data_o = rd_data[1];

  for (genvar p = 0; p < RF_READ_PORTS; p++) begin : g_rd
    always_comb begin
      rd_data[p] = '0;
      if (ready_o && rd_en[p] && (rd_addr[p] != '0)) begin
        if (BYPASS_EN && write_enable_i && (write_address_i == rd_addr[p]))
          rd_data[p] = write_data_i;
        else
          rd_data[p] = regs[rd_addr[p]];
      end
    end
  end
endmodule
